multi_cycle_trace_monitor: RTL
==============================

# multi_cycle_trace_monitor

Synthesisable, parametrised execution monitor that sits beside the multi-cycle CPU `top` and observes its debug outputs: pc, instruction, register indices and data, branch and zero. It counts cycles, retired instructions and taken branches, and stores an instruction trace in a ring buffer that can be drained through a valid/ready port. It detects program halt (a self-loop) and runaway execution (timeout), so both benches and on-board debug can end a run deterministically.

## Interface
Parameters:
- `XLEN`, 32, datapath width of pc, instruction and register data
- `DEPTH`, 16, trace entries; power of two, ≥2
- `HALT_REPEAT`, 4, consecutive fetches of the same pc that declare a halt; ≥2
- `TIMEOUT`, 4096, cycle limit in RUN before a timeout is declared
- `OVERWRITE`, 1, trace-full policy: 1 overwrites the oldest entry, 0 drops the new one

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `fetch`  in  1  one-cycle pulse when the CPU latches a new instruction
- `pc`  in  XLEN  pc of the fetched instruction
- `IDataOut`  in  32  fetched instruction word
- `branch`  in  1  branch instruction in execute
- `zero`  in  1  ALU zero flag
- `rd_valid`  out  1  trace entry available
- `rd_ready`  in  1  consumer accepts the entry
- `rd_data`  out  XLEN+32+1  {pc, instr, taken}, oldest first
- `level`  out  $clog2(DEPTH)+1  occupancy
- `overflow`  out  1  sticky; set when an entry was lost
- `cycle_count`  out  32  cycles spent in RUN
- `instr_count`  out  32  fetches in RUN
- `taken_count`  out  32  taken branches
- `halted`  out  1  sticky halt indication
- `timeout`  out  1  sticky timeout indication

## Operation
- Reset: all outputs are 0, the trace is empty, and the FSM enters IDLE.
- FSM states: IDLE, RUN, HALTED, TIMEOUT.
  - IDLE→RUN on the first `fetch`. That fetch is counted and pushed.
  - RUN→HALTED when `HALT_REPEAT` consecutive fetches present the same pc.
  - RUN→TIMEOUT when `cycle_count` reaches `TIMEOUT-1` and increments.
  - If HALTED and TIMEOUT conditions occur in the same cycle, HALTED wins.
  - HALTED and TIMEOUT are absorbing until `rst`.
- Counting in RUN:
  - `cycle_count` increments every cycle.
  - `instr_count` increments on each `fetch`.
  - All counters freeze outside RUN and wrap modulo 2^32.
- Taken branch:
  - Observing `branch & zero` sets the taken flag of the newest entry and increments `taken_count`.
  - This happens at most once per instruction. An internal per-instruction flag clears on `fetch`.
  - If the entry was already popped, only the counter updates.
- Trace push occurs on `fetch` in IDLE or RUN: {pc, IDataOut, 0}.
- Trace pop occurs when `rd_valid & rd_ready`.
- Full with push and no pop:
  - `OVERWRITE=1`: the oldest entry is discarded, the read pointer advances, and `level` stays at DEPTH.
  - `OVERWRITE=0`: the new entry is dropped.
  - Either way, `overflow` is set.
- Full with push and pop together: both happen, `level` is unchanged, and `overflow` is not set.
- Empty with push and pop together: only the push happens (`rd_valid` is 0).
- Draining continues in HALTED/TIMEOUT. Pushes stop there.
- Halt repeat counter: resets to 1 whenever the fetched pc differs from the previous fetched pc.

## Timing
- All outputs are registered. Flags and counters change one cycle after the triggering input edge.
- `rd_valid`/`rd_data` reflect the head entry. They update the cycle after a push into an empty buffer or after a pop.
- `rd_data` is held stable while `rd_valid & !rd_ready`.
- `halted` asserts the cycle after the `HALT_REPEAT`-th matching fetch.
- `rst` asserted mid-run clears everything on the next edge, including sticky flags and trace contents.

## Structure
- Package `trace_pkg`: FSM state enum, trace entry struct, `ENTRY_W` function of `XLEN`.
- Sub-module `trace_ring` (parametrised storage, pointers, level, overwrite policy). The FSM and counters live in the top module.

## Test plan
- Reset, then 3 fetches at pc 0, 4, 8 with no pop → `level`=3, `instr_count`=3, and draining yields pcs 0, 4, 8 in order.
- DEPTH=4, OVERWRITE=1, 6 fetches (pc 0..20) without pop → `level`=4, `overflow`=1, drain yields pc 8, 12, 16, 20. With OVERWRITE=0 the drain yields 0..12.
- Branch fetch at pc 0x10, then `branch=zero=1` held 3 cycles → `taken_count`=1 and the entry's taken bit is 1.
- Fetches at pc 0x20 ×4 (HALT_REPEAT=4) → `halted`=1 the next cycle, counters frozen, trace still drainable.
- TIMEOUT=50 with fetches never repeating → `timeout`=1 and `cycle_count`=50.
- Full buffer with push and pop in the same cycle → `level` stays DEPTH and `overflow` stays 0. `rst` mid-run → all outputs 0 the next cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, state encoding and entry layout for the trace monitor
package trace_pkg;

    localparam int INSTR_W = 32;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // Low part of a trace entry; the pc sits above it and is XLEN wide.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               taken;
    } entry_lo_t;

    // Full entry width {pc, instr, taken} for a given datapath width.
    function automatic int entry_w(input int xlen);
        return xlen + INSTR_W + 1;
    endfunction

endpackage

// File: rtl/trace_ring.sv
// rtl/trace_ring.sv - ring buffer for trace entries with overwrite/drop policy on full
module trace_ring #(
    parameter int W         = 65,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       mark,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic pop;
    logic do_write;
    logic drop_head;
    logic lost;
    logic [AW-1:0] newest;

    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = (count != '0) && rd_ready;
    // A push into a full buffer with no pop either evicts the head or is dropped.
    assign lost      = push && full && !pop;
    assign do_write  = push && (!full || pop || (OVERWRITE != 0));
    assign drop_head = lost && (OVERWRITE != 0);
    assign newest    = wr_ptr - AW'(1);

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop || drop_head)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !full && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
            if (lost)
                overflow <= 1'b1;
        end
    end

    // Entry storage; the taken mark always lands on the most recently written entry.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= push_data;
        if (mark && (count != '0))
            mem[newest][0] <= 1'b1;
    end

    // Head entry is shown only while the buffer holds something, so reset reads as zero.
    always_comb begin
        rd_valid = (count != '0);
        rd_data  = rd_valid ? mem[rd_ptr] : '0;
        level    = count;
    end

endmodule

// File: rtl/multi_cycle_trace_monitor.sv
// rtl/multi_cycle_trace_monitor.sv - execution monitor: run FSM, counters, halt/timeout detection, trace capture
module multi_cycle_trace_monitor
    import trace_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 4,
    parameter int TIMEOUT     = 4096,
    parameter int OVERWRITE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch,
    input  logic [XLEN-1:0]              pc,
    input  logic [31:0]                  IDataOut,
    input  logic                         branch,
    input  logic                         zero,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [XLEN+32:0]             rd_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic [31:0]                  cycle_count,
    output logic [31:0]                  instr_count,
    output logic [31:0]                  taken_count,
    output logic                         halted,
    output logic                         timeout
);

    localparam int EW = entry_w(XLEN);
    localparam int RW = $clog2(HALT_REPEAT + 1);

    fsm_state_t     state;
    logic [XLEN-1:0] last_pc;
    logic [RW-1:0]   rep;
    logic            taken_seen;

    logic            in_run;
    logic            active;
    logic            push;
    logic            taken_evt;
    logic [RW-1:0]   rep_next;
    logic            halt_hit;
    logic            time_hit;
    entry_lo_t       entry_lo;
    logic [EW-1:0]   push_data;

    // Decode of the current cycle's events from state and CPU debug signals.
    always_comb begin
        in_run    = (state == ST_RUN);
        active    = in_run || (state == ST_IDLE);
        push      = fetch && active;
        taken_evt = in_run && branch && zero && !taken_seen;
        rep_next  = (in_run && (pc == last_pc)) ? rep + RW'(1) : RW'(1);
        halt_hit  = in_run && fetch && (rep_next == RW'(HALT_REPEAT));
        time_hit  = in_run && (cycle_count == 32'(TIMEOUT - 1));
        entry_lo  = '{instr: IDataOut, taken: 1'b0};
        push_data = {pc, entry_lo};
    end

    // Run-state FSM; halt takes priority over timeout and both are absorbing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (fetch) state <= ST_RUN;
                ST_RUN:     if (halt_hit) state <= ST_HALTED;
                            else if (time_hit) state <= ST_TIMEOUT;
                default:    state <= state;
            endcase
        end
    end

    // Cycle, instruction and taken-branch counters; the first fetch in IDLE counts too.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
            taken_count <= '0;
        end else begin
            if (in_run)
                cycle_count <= cycle_count + 32'd1;
            if (push)
                instr_count <= instr_count + 32'd1;
            if (taken_evt)
                taken_count <= taken_count + 32'd1;
        end
    end

    // Same-pc repeat tracking and the once-per-instruction taken latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc    <= '0;
            rep        <= '0;
            taken_seen <= 1'b0;
        end else begin
            if (push) begin
                rep     <= rep_next;
                last_pc <= pc;
            end
            taken_seen <= fetch ? 1'b0 : (taken_seen | taken_evt);
        end
    end

    assign halted  = (state == ST_HALTED);
    assign timeout = (state == ST_TIMEOUT);

    trace_ring #(
        .W         (EW),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .mark      (taken_evt),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .level     (level),
        .overflow  (overflow)
    );

endmodule
